sprite_mover: RTL and testbench

Parametrised player-sprite position controller for the VGA game, driven by `clk_22`. It converts keyboard direction bits into per-axis saturating moves inside a configurable play-field and handles death on a collision event. It also runs a respawn cooldown, a post-respawn invulnerability window with blinking display, and a lives counter ending in game-over. The outputs feed the renderer and the collision/memory generator.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/axis_step.sv | 47 ++++
 rtl/sprite_mover.sv | 148 ++++++++++++++
 tb/tb_sprite_mover.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and bit indices for the player sprite controller.
// Imported by the sprite_mover top and its axis_step sub-module.
package sprite_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    DEAD,
    INVULN,
    OVER
  } state_t;

  localparam int UP = 3;
  localparam int DN = 2;
  localparam int LF = 1;
  localparam int RT = 0;

  localparam int BLINK = 2;

endpackage

// File: rtl/axis_step.sv
// One-axis direction decode plus saturating step.
// Outputs the unchanged position when not enabled.
module axis_step #(
  parameter int W    = 10,
  parameter int STEP = 5,
  parameter int MIN  = 3,
  parameter int MAX  = 636
) (
  input  logic [W-1:0] pos,
  input  logic         neg,
  input  logic         plus,
  input  logic         enable,
  output logic [W-1:0] next
);

  localparam logic signed [W+1:0] S  = (W+2)'(STEP);
  localparam logic signed [W+1:0] LO = (W+2)'(MIN);
  localparam logic signed [W+1:0] HI = (W+2)'(MAX);

  logic signed [W+1:0] d;
  logic signed [W+1:0] sum;

  always_comb begin
    d = '0;
    unique case ({neg, plus})
      2'b10:   d = -S;
      2'b01:   d = S;
      default: d = '0;
    endcase
  end

  // Two guard bits keep the sum signed and wrap-free
  assign sum = $signed({2'b00, pos}) + d;

  always_comb begin
    next = pos;
    if (enable) begin
      if (sum < LO)
        next = W'(MIN);
      else if (sum > HI)
        next = W'(MAX);
      else
        next = sum[W-1:0];
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Player sprite position, death/respawn timing and lives.
// FSM state, counter, lives and position are all registered.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int W           = 10,
  parameter int STEP        = 5,
  parameter int X_MIN       = 3,
  parameter int X_MAX       = 636,
  parameter int Y_MIN       = 3,
  parameter int Y_MAX       = 476,
  parameter int SPAWN_X     = 100,
  parameter int SPAWN_Y     = 140,
  parameter int RESPAWN_CYC = 100,
  parameter int INVULN_CYC  = 32,
  parameter int LIVES       = 3,
  parameter int LW          = $clog2(LIVES+1)
) (
  input  logic          clk_22,
  input  logic          rst,
  input  logic          pause,
  input  logic [3:0]    move_opr,
  input  logic          hit,
  output logic [W-1:0]  pos_x,
  output logic [W-1:0]  pos_y,
  output logic          show_valid,
  output logic          invuln,
  output logic [LW-1:0] lives,
  output logic          game_over
);

  localparam int MAXC = (RESPAWN_CYC > INVULN_CYC) ?
                        RESPAWN_CYC : INVULN_CYC;
  localparam int CB   = $clog2(MAXC+1);
  // Wide enough to always expose the blink bit
  localparam int CW   = (CB > BLINK) ? CB : BLINK+1;

  localparam logic [CW-1:0] R_END = CW'(RESPAWN_CYC-1);
  localparam logic [CW-1:0] I_END = CW'(INVULN_CYC-1);
  localparam logic [W-1:0]  SX    = W'(SPAWN_X);
  localparam logic [W-1:0]  SY    = W'(SPAWN_Y);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] lv, lv_n;
  logic [W-1:0]  px, px_n, nx;
  logic [W-1:0]  py, py_n, ny;
  logic          mv;

  assign mv = !pause &&
              ((state == INVULN) ||
               (state == ALIVE && !hit));

  axis_step #(
    .W(W), .STEP(STEP),
    .MIN(X_MIN), .MAX(X_MAX)
  ) u_x (
    .pos(px),
    .neg(move_opr[LF]),
    .plus(move_opr[RT]),
    .enable(mv),
    .next(nx)
  );

  axis_step #(
    .W(W), .STEP(STEP),
    .MIN(Y_MIN), .MAX(Y_MAX)
  ) u_y (
    .pos(py),
    .neg(move_opr[UP]),
    .plus(move_opr[DN]),
    .enable(mv),
    .next(ny)
  );

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      state <= ALIVE;
      cnt   <= '0;
      lv    <= LW'(LIVES);
      px    <= SX;
      py    <= SY;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lv    <= lv_n;
      px    <= px_n;
      py    <= py_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lv_n    = lv;
    px_n    = nx;
    py_n    = ny;
    if (!pause) begin
      unique case (state)
        ALIVE: begin
          if (hit) begin
            lv_n    = lv - 1'b1;
            px_n    = SX;
            py_n    = SY;
            cnt_n   = '0;
            state_n = (lv == LW'(1)) ? OVER : DEAD;
          end
        end
        DEAD: begin
          if (cnt == R_END) begin
            state_n = INVULN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        INVULN: begin
          if (cnt == I_END) begin
            state_n = ALIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        OVER: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    show_valid = 1'b0;
    unique case (state)
      ALIVE:   show_valid = 1'b1;
      INVULN:  show_valid = ~cnt[BLINK];
      default: show_valid = 1'b0;
    endcase
  end

  assign pos_x     = px;
  assign pos_y     = py;
  assign invuln    = (state == INVULN);
  assign game_over = (state == OVER);
  assign lives     = lv;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed and random stimulus for sprite_mover with a
// behavioural reference model of motion, timing and lives.
module tb_sprite_mover;

  localparam int W  = 10;
  localparam int ST = 5;
  localparam int XL = 3;
  localparam int XH = 636;
  localparam int YL = 3;
  localparam int YH = 476;
  localparam int SX = 100;
  localparam int SY = 140;
  localparam int RC = 100;
  localparam int IC = 32;
  localparam int LV = 3;
  localparam int LW = $clog2(LV+1);

  logic          clk_22 = 1'b0;
  logic          rst;
  logic          pause;
  logic [3:0]    move_opr;
  logic          hit;
  logic [W-1:0]  pos_x;
  logic [W-1:0]  pos_y;
  logic          show_valid;
  logic          invuln;
  logic [LW-1:0] lives;
  logic          game_over;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 alive, 1 dead, 2 invulnerable, 3 over
  int mx, my, ml, mode, age;

  sprite_mover dut (
    .clk_22(clk_22),
    .rst(rst),
    .pause(pause),
    .move_opr(move_opr),
    .hit(hit),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .show_valid(show_valid),
    .invuln(invuln),
    .lives(lives),
    .game_over(game_over)
  );

  always #5 clk_22 = ~clk_22;

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = SX; my = SY; ml = LV;
    mode = 0; age = 0;
  endtask

  task automatic model_move();
    int dx, dy;
    dx = (move_opr[0] ? ST : 0) - (move_opr[1] ? ST : 0);
    dy = (move_opr[2] ? ST : 0) - (move_opr[3] ? ST : 0);
    mx = clamp(mx + dx, XL, XH);
    my = clamp(my + dy, YL, YH);
  endtask

  task automatic model_step();
    if (pause) return;
    case (mode)
      0: begin
        if (hit) begin
          ml = ml - 1;
          mx = SX; my = SY; age = 0;
          mode = (ml == 0) ? 3 : 1;
        end else begin
          model_move();
        end
      end
      1: begin
        age++;
        if (age == RC) begin
          mode = 2; age = 0;
        end
      end
      2: begin
        model_move();
        age++;
        if (age == IC) begin
          mode = 0; age = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sv;
    sv = (mode == 0) ? 1 :
         (mode == 2) ? (((age / 4) % 2) == 0 ? 1 : 0) : 0;
    chk("pos_x", 32'(pos_x), mx);
    chk("pos_y", 32'(pos_y), my);
    chk("show_valid", 32'(show_valid), sv);
    chk("invuln", 32'(invuln), (mode == 2) ? 1 : 0);
    chk("lives", 32'(lives), ml);
    chk("game_over", 32'(game_over), (mode == 3) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk_22);
    model_step();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    chk("rst_x", 32'(pos_x), SX);
    chk("rst_lives", 32'(lives), LV);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; pause = 1'b0;
    hit = 1'b0; move_opr = 4'b0000;
    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    move_opr = 4'b0001;
    tick(); chk("r1", 32'(pos_x), 105);
    tick(); chk("r2", 32'(pos_x), 110);
    tick(); chk("r3", 32'(pos_x), 115);
    chk("r_y", 32'(pos_y), 140);

    move_opr = 4'b0010;
    repeat (22) tick();
    chk("at5", 32'(pos_x), 5);
    move_opr = 4'b1010;
    repeat (3) tick();
    chk("slide_x", 32'(pos_x), 3);
    chk("slide_y", 32'(pos_y), 125);
    move_opr = 4'b0011;
    repeat (2) tick();
    chk("lr_x", 32'(pos_x), 3);

    for (int i = 0; i < 200; i++) begin
      move_opr = 4'($urandom);
      pause = ($urandom_range(0, 9) == 0);
      tick();
    end
    pause = 1'b0;

    hit = 1'b1; tick(); hit = 1'b0;
    chk("hit_show", 32'(show_valid), 0);
    chk("hit_lives", 32'(lives), 2);
    chk("hit_x", 32'(pos_x), SX);
    for (int i = 0; i < 140; i++) begin
      move_opr = 4'($urandom);
      hit = (i < 100) && ($urandom_range(0, 3) == 0);
      tick();
    end
    hit = 1'b0;
    chk("alive_show", 32'(show_valid), 1);

    hit = 1'b1;
    tick();
    chk("hold_l1", 32'(lives), 1);
    repeat (RC + IC) tick();
    chk("hold_l2", 32'(lives), 1);
    chk("hold_alive", 32'(show_valid), 1);
    tick();
    chk("hold_over", 32'(game_over), 1);
    chk("hold_l0", 32'(lives), 0);
    for (int i = 0; i < 30; i++) begin
      move_opr = 4'($urandom);
      hit = 1'($urandom);
      tick();
    end
    hit = 1'b0;
    chk("over_x", 32'(pos_x), SX);

    async_reset();

    move_opr = 4'b0101;
    repeat (4) tick();
    hit = 1'b1; tick(); hit = 1'b0;
    repeat (50) tick();
    pause = 1'b1;
    repeat (20) tick();
    pause = 1'b0;
    repeat (49) tick();
    chk("pz_dead", 32'(invuln), 0);
    tick();
    chk("pz_inv", 32'(invuln), 1);
    repeat (10) tick();
    async_reset();

    for (int h = 0; h < 3; h++) begin
      move_opr = 4'($urandom);
      repeat (3) tick();
      hit = 1'b1; tick(); hit = 1'b0;
      if (h < 2) repeat (RC + IC + 2) tick();
    end
    chk("three_go", 32'(game_over), 1);
    chk("three_show", 32'(show_valid), 0);
    chk("three_l0", 32'(lives), 0);
    for (int i = 0; i < 30; i++) begin
      move_opr = 4'($urandom);
      hit = 1'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
